// File: rtl/mac_dot_sequencer.sv
// Sequences one fixed-latency pipelined FMA (q = a*b + c) to accumulate streamed dot products.
// Optional DOTSEQ_BIAS_EN adds a datainC port used as the initial accumulator.
module mac_dot_sequencer #(
    parameter int unsigned MAC_LATENCY = 9,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ivalid,
    output logic             oready,
    input  logic [31:0]      datainA,
    input  logic [31:0]      datainB,
`ifdef DOTSEQ_BIAS_EN
    input  logic [31:0]      datainC,
`endif
    input  logic             ilast,
    output logic [31:0]      mac_a,
    output logic [31:0]      mac_b,
    output logic [31:0]      mac_c,
    input  logic [31:0]      mac_q,
    output logic [31:0]      dataout,
    output logic [CNT_W-1:0] count,
    output logic             ovalid,
    input  logic             iready,
    output logic             busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WAIT_W = $clog2(MAC_LATENCY);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MAC_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]    elem_cnt;
    logic                last_q;
    logic                fresh_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   bias_c;

`ifdef DOTSEQ_BIAS_EN
    assign bias_c = datainC;
`else
    assign bias_c = '0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and accept decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, ACC: begin
                if (ivalid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = last_q ? OUT : ACC;
                end
            end
            OUT: begin
                if (ovalid && iready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand issue, latency counter, accumulator capture and output registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            oready   <= 1'b1;
            busy     <= 1'b0;
            ovalid   <= 1'b0;
            dataout  <= '0;
            count    <= '0;
            mac_a    <= '0;
            mac_b    <= '0;
            mac_c    <= '0;
            wait_cnt <= '0;
            elem_cnt <= '0;
            last_q   <= 1'b0;
            fresh_q  <= 1'b0;
            acc_q    <= '0;
        end else begin
            oready  <= (state_next == IDLE) || (state_next == ACC);
            busy    <= (state_next != IDLE);
            fresh_q <= (state == WAIT) && (state_next == ACC);

            if (accept) begin
                mac_a    <= datainA;
                mac_b    <= datainB;
                last_q   <= ilast;
                wait_cnt <= WAIT_LOAD;
                if (state == IDLE) begin
                    mac_c    <= bias_c;
                    elem_cnt <= CNT_W'(1);
                end else begin
                    // mac_q is only valid on the first ACC cycle; later accepts use the held copy
                    mac_c    <= fresh_q ? mac_q : acc_q;
                    elem_cnt <= (elem_cnt == CNT_MAX) ? elem_cnt : elem_cnt + CNT_W'(1);
                end
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end

            if ((state == ACC) && fresh_q) begin
                acc_q <= mac_q;
            end

            // First OUT cycle captures the final sum; ovalid follows one cycle later
            if (state == OUT) begin
                if (!ovalid) begin
                    ovalid  <= 1'b1;
                    dataout <= mac_q;
                    count   <= elem_cnt;
                end else if (iready) begin
                    ovalid  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with behavioural latency-9 FMA models.
// A second instance with CNT_W=2 shares the stimulus to observe counter saturation.
module tb_mac_dot_sequencer;

    localparam int unsigned LAT = 9;

    logic        clock = 1'b0;
    logic        resetn;
    logic        ivalid;
    logic        ilast;
    logic        iready;
    logic [31:0] datainA;
    logic [31:0] datainB;
`ifdef DOTSEQ_BIAS_EN
    logic [31:0] datainC;
`endif

    logic        oready, ovalid, busy;
    logic [31:0] mac_a, mac_b, mac_c, mac_q, dataout;
    logic [15:0] count;

    logic        oready1, ovalid1, busy1;
    logic [31:0] mac_a1, mac_b1, mac_c1, mac_q1, dataout1;
    logic [1:0]  count1;

    logic [31:0] pipe0 [LAT];
    logic [31:0] pipe1 [LAT];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mac_dot_sequencer #(.MAC_LATENCY(LAT), .CNT_W(16)) dut (
        .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready),
        .datainA(datainA), .datainB(datainB),
`ifdef DOTSEQ_BIAS_EN
        .datainC(datainC),
`endif
        .ilast(ilast), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_q(mac_q),
        .dataout(dataout), .count(count), .ovalid(ovalid), .iready(iready), .busy(busy)
    );

    mac_dot_sequencer #(.MAC_LATENCY(LAT), .CNT_W(2)) dut_sat (
        .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready1),
        .datainA(datainA), .datainB(datainB),
`ifdef DOTSEQ_BIAS_EN
        .datainC(datainC),
`endif
        .ilast(ilast), .mac_a(mac_a1), .mac_b(mac_b1), .mac_c(mac_c1), .mac_q(mac_q1),
        .dataout(dataout1), .count(count1), .ovalid(ovalid1), .iready(iready), .busy(busy1)
    );

    // Single-precision <-> real for normal numbers and zero, enough for these vectors
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    always @(posedge clock) begin
        pipe0[0] <= r2f(f2r(mac_a) * f2r(mac_b) + f2r(mac_c));
        pipe1[0] <= r2f(f2r(mac_a1) * f2r(mac_b1) + f2r(mac_c1));
        for (int i = 1; i < LAT; i++) begin
            pipe0[i] <= pipe0[i-1];
            pipe1[i] <= pipe1[i-1];
        end
    end
    assign mac_q  = pipe0[LAT-1];
    assign mac_q1 = pipe1[LAT-1];

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                        output int acc_cyc, output bit ok);
        datainA = a; datainB = b; ilast = last; ivalid = 1'b1;
        ok = 1'b0; acc_cyc = -1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (oready) begin
                acc_cyc = cyc;
                ok = 1'b1;
            end
            @(posedge clock); #1;
        end
        ivalid = 1'b0; ilast = 1'b0;
    endtask

    task automatic wait_ovalid(output int t, output bit ok);
        ok = 1'b0; t = -1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (ovalid) begin
                t = cyc;
                ok = 1'b1;
            end else begin
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic release_out;
        iready = 1'b1;
        @(posedge clock); #1;
        iready = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; ivalid = 1'b0; ilast = 1'b0; iready = 1'b0;
        datainA = '0; datainB = '0;
`ifdef DOTSEQ_BIAS_EN
        datainC = '0;
`endif
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        vectors++;
        if ({oready, ovalid, busy} !== 3'b100) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 100", {oready, ovalid, busy});
        end
        vectors++;
        if (dataout !== 32'h0 || count !== 16'h0) begin
            miscompares++; $display("FAIL reset_out: got %h/%0d expected 0/0", dataout, count);
        end
        vectors++;
        if ({mac_a, mac_b, mac_c} !== 96'h0) begin
            miscompares++; $display("FAIL reset_mac: got %h %h %h expected 0", mac_a, mac_b, mac_c);
        end
    endtask

    task automatic test_two_element;
        int k1, k2, t;
        bit ok1, ok2, ok3;
        send(32'h3F800000, 32'h40000000, 1'b0, k1, ok1);
        send(32'h40400000, 32'h40800000, 1'b1, k2, ok2);
        vectors++;
        if (!(ok1 && ok2) || (k2 - k1) !== 10) begin
            miscompares++; $display("FAIL two_elem_period: got %0d expected 10", k2 - k1);
        end
        vectors++;
        if (mac_c !== 32'h40000000 || mac_a !== 32'h40400000) begin
            miscompares++; $display("FAIL two_elem_operands: got c=%h a=%h expected 40000000 40400000", mac_c, mac_a);
        end
        wait_ovalid(t, ok3);
        vectors++;
        if (!ok3 || (t - k2) !== 11) begin
            miscompares++; $display("FAIL two_elem_ovalid_latency: got %0d expected 11", t - k2);
        end
        vectors++;
        if (dataout !== 32'h41600000 || count !== 16'd2) begin
            miscompares++; $display("FAIL two_elem_result: got %h/%0d expected 41600000/2", dataout, count);
        end
        release_out();
        vectors++;
        if ({oready, ovalid, busy} !== 3'b100) begin
            miscompares++; $display("FAIL two_elem_handshake: got %b expected 100", {oready, ovalid, busy});
        end
    endtask

    task automatic test_single_element;
        int k, t;
        bit ok1, ok2;
        logic [31:0] exp_sum;
`ifdef DOTSEQ_BIAS_EN
        datainC = 32'h3F800000;
        exp_sum = 32'h40E00000;
`else
        exp_sum = 32'h40C00000;
`endif
        send(32'h40000000, 32'h40400000, 1'b1, k, ok1);
`ifdef DOTSEQ_BIAS_EN
        datainC = '0;
`endif
        wait_ovalid(t, ok2);
        vectors++;
        if (!(ok1 && ok2) || dataout !== exp_sum || count !== 16'd1) begin
            miscompares++; $display("FAIL single_result: got %h/%0d expected %h/1", dataout, count, exp_sum);
        end
        release_out();
    endtask

    task automatic test_back_to_back;
        int k [4];
        int t;
        bit ok, okw;
        bit all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h3F800000, 32'h3F800000, (i == 3), k[i], ok);
            all_ok = all_ok && ok;
        end
        for (int i = 1; i < 4; i++) begin
            vectors++;
            if (!all_ok || (k[i] - k[i-1]) !== 10) begin
                miscompares++; $display("FAIL b2b_period_%0d: got %0d expected 10", i, k[i] - k[i-1]);
            end
        end
        wait_ovalid(t, okw);
        vectors++;
        if (!okw || dataout !== 32'h40800000 || count !== 16'd4) begin
            miscompares++; $display("FAIL b2b_result: got %h/%0d expected 40800000/4", dataout, count);
        end
        release_out();
    endtask

    task automatic test_backpressure;
        int k, t, k2;
        bit ok1, ok2, ok3, ok4;
        bit stable = 1'b1;
        send(32'h40000000, 32'h40400000, 1'b1, k, ok1);
        wait_ovalid(t, ok2);
        datainA = 32'h40A00000; datainB = 32'h40A00000; ivalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (dataout !== 32'h40C00000 || !ovalid || oready || mac_a !== 32'h40000000) stable = 1'b0;
        end
        vectors++;
        if (!(ok1 && ok2) || !stable) begin
            miscompares++; $display("FAIL backpressure_hold: got dataout=%h ovalid=%b oready=%b expected 40C00000 1 0", dataout, ovalid, oready);
        end
        ivalid = 1'b0;
        release_out();
        vectors++;
        if ({oready, ovalid, busy} !== 3'b100) begin
            miscompares++; $display("FAIL backpressure_release: got %b expected 100", {oready, ovalid, busy});
        end
        send(32'h3F800000, 32'h40000000, 1'b1, k2, ok3);
        wait_ovalid(t, ok4);
        vectors++;
        if (!(ok3 && ok4) || dataout !== 32'h40000000 || count !== 16'd1) begin
            miscompares++; $display("FAIL backpressure_next: got %h/%0d expected 40000000/1", dataout, count);
        end
        release_out();
    endtask

    task automatic test_reset_mid;
        int k, t;
        bit ok1, ok2, ok3;
        send(32'h3F800000, 32'h40000000, 1'b0, k, ok1);
        vectors++;
        if (!ok1 || busy !== 1'b1 || oready !== 1'b0) begin
            miscompares++; $display("FAIL midreset_wait: got busy=%b oready=%b expected 1 0", busy, oready);
        end
        repeat (2) @(posedge clock);
        #1 resetn = 1'b0;
        @(posedge clock); #1 resetn = 1'b1;
        vectors++;
        if ({oready, ovalid, busy} !== 3'b100 || {mac_a, mac_b, mac_c} !== 96'h0 || dataout !== 32'h0 || count !== 16'h0) begin
            miscompares++; $display("FAIL midreset_values: got flags=%b a=%h b=%h c=%h d=%h n=%0d expected 100 and zeros",
                                    {oready, ovalid, busy}, mac_a, mac_b, mac_c, dataout, count);
        end
        send(32'h3F800000, 32'h40000000, 1'b1, k, ok2);
        wait_ovalid(t, ok3);
        vectors++;
        if (!(ok2 && ok3) || dataout !== 32'h40000000 || count !== 16'd1) begin
            miscompares++; $display("FAIL midreset_next: got %h/%0d expected 40000000/1", dataout, count);
        end
        release_out();
    endtask

    task automatic test_saturation;
        int k, t;
        bit ok, okw;
        bit all_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(32'h3F800000, 32'h3F800000, (i == 4), k, ok);
            all_ok = all_ok && ok;
        end
        wait_ovalid(t, okw);
        vectors++;
        if (!(all_ok && okw) || dataout !== 32'h40A00000 || count !== 16'd5) begin
            miscompares++; $display("FAIL sat_wide: got %h/%0d expected 40A00000/5", dataout, count);
        end
        vectors++;
        if (ovalid1 !== 1'b1 || dataout1 !== 32'h40A00000 || count1 !== 2'd3) begin
            miscompares++; $display("FAIL sat_narrow: got %b %h/%0d expected 1 40A00000/3", ovalid1, dataout1, count1);
        end
        release_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_two_element();
        test_single_element();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
